// File: rtl/unisim_sram_b_param.sv
// Parametrised 1-write/1-read SRAM wrapper for accelerator local memories.
// Storage is split into 2^(ABITS-BANK_ABITS) behavioural banks sized for
// block-RAM inference. After reset an optional sequence zeroes every word
// while BUSY is high. Each bank read is registered and read-first, so the
// array always returns the old word. Write-first behaviour on a same-address
// collision is rebuilt from the write data and mask, which are captured
// alongside the read. An optional output register adds one cycle of latency.

module unisim_sram_b_param #(
  parameter int ABITS         = 7,
  parameter int DBITS         = 8,
  parameter int BANK_ABITS    = 11,
  parameter int OUT_REG       = 0,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE0,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic             WE0,
  input  logic [DBITS-1:0] WEM0,
  input  logic             CE1,
  input  logic [ABITS-1:0] A1,
  output logic [DBITS-1:0] Q1,
  output logic             Q1_VALID,
  output logic             BUSY
);

  // The local address is the part of the word address that lives inside one bank.
  localparam int LBITS  = (ABITS < BANK_ABITS) ? ABITS : BANK_ABITS;
  localparam int XBITS  = (ABITS > BANK_ABITS) ? (ABITS - BANK_ABITS) : 0;
  localparam int NBANKS = 1 << XBITS;
  localparam int SBITS  = (XBITS > 0) ? XBITS : 1;
  localparam int WORDS  = 1 << LBITS;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LBITS-1:0] ic;
  logic             busy;
  logic             wr_en;
  logic             rd_en;
  logic [LBITS-1:0] wr_lo;
  logic [LBITS-1:0] rd_lo;
  logic [SBITS-1:0] wr_bank;
  logic [DBITS-1:0] bank_q [NBANKS];
  logic [DBITS-1:0] q_raw;
  logic [DBITS-1:0] q_comb;
  logic             rd_v1;
  logic             coll_r;
  logic [DBITS-1:0] fwd_d;
  logic [DBITS-1:0] fwd_m;

  // State register: reset enters the zeroing sequence unless it is disabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave INIT once the last local address has been cleared.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_INIT: begin
        busy = 1'b1;
        if (ic == LBITS'(WORDS - 1)) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = ST_READY;
      end
    endcase
  end

  // The init counter walks the local address space; all banks clear in parallel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ic <= '0;
    end else if (state == ST_INIT) begin
      ic <= ic + 1'b1;
    end
  end

  assign BUSY  = busy;
  assign wr_en = ~busy & CE0 & WE0;
  assign rd_en = ~busy & CE1;
  assign wr_lo = A0[LBITS-1:0];
  assign rd_lo = A1[LBITS-1:0];

  if (XBITS > 0) begin : g_sel
    logic [XBITS-1:0] rd_bank_r;

    assign wr_bank = A0[ABITS-1:BANK_ABITS];

    // The bank select travels with the read so the output mux matches the data.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        rd_bank_r <= '0;
      end else if (rd_en) begin
        rd_bank_r <= A1[ABITS-1:BANK_ABITS];
      end
    end

    assign q_raw = bank_q[rd_bank_r];
  end else begin : g_nosel
    assign wr_bank = '0;
    assign q_raw   = bank_q[0];
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [DBITS-1:0] mem [WORDS];
    logic [DBITS-1:0] rd_q;
    logic             bank_we;

    assign bank_we = wr_en && (wr_bank == SBITS'(b));

    // Array write port: zero fill during init, otherwise a per-bit masked update.
    always_ff @(posedge CLK) begin
      if (busy) begin
        mem[ic] <= '0;
      end else if (bank_we) begin
        mem[wr_lo] <= (mem[wr_lo] & ~WEM0) | (D0 & WEM0);
      end
    end

    // Registered read-first port. It holds its value while no read is issued.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        rd_q <= '0;
      end else if (rd_en) begin
        rd_q <= mem[rd_lo];
      end
    end

    assign bank_q[b] = rd_q;
  end

  // Capture the read-valid flag and, for a same-address write, the merge operands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_v1  <= 1'b0;
      coll_r <= 1'b0;
      fwd_d  <= '0;
      fwd_m  <= '0;
    end else begin
      rd_v1 <= rd_en;
      if (rd_en) begin
        coll_r <= wr_en && (A0 == A1);
        fwd_d  <= D0;
        fwd_m  <= WEM0;
      end
    end
  end

  assign q_comb = ((BYPASS != 0) && coll_r) ? ((q_raw & ~fwd_m) | (fwd_d & fwd_m)) : q_raw;

  if (OUT_REG != 0) begin : g_oreg
    logic [DBITS-1:0] q_r;
    logic             v_r;

    // Optional output stage. It loads only when a read result arrives.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q_r <= '0;
        v_r <= 1'b0;
      end else begin
        v_r <= rd_v1;
        if (rd_v1) begin
          q_r <= q_comb;
        end
      end
    end

    assign Q1       = q_r;
    assign Q1_VALID = v_r;
  end else begin : g_nooreg
    assign Q1       = q_comb;
    assign Q1_VALID = rd_v1;
  end

endmodule

// File: tb/tb_unisim_sram_b_param.sv
// Scoreboard bench for unisim_sram_b_param. It drives two instances from the
// same stimulus:
//   dut_a: single bank, 8-bit data, write-first collisions, latency 1.
//   dut_b: two banks, 16-bit data, read-first collisions, latency 2.
// A word-array model predicts every read result and its arrival cycle.

module tb_unisim_sram_b_param;

  localparam int INIT_WORDS = 128;
  localparam int BYP_A = 1;
  localparam int BYP_B = 0;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce0 = 1'b0;
  logic        we0 = 1'b0;
  logic        ce1 = 1'b0;
  logic [7:0]  a0 = '0;
  logic [7:0]  a1 = '0;
  logic [15:0] d0 = '0;
  logic [15:0] wem0 = '0;

  logic [7:0]  q1_a;
  logic        q1_valid_a;
  logic        busy_a;
  logic [15:0] q1_b;
  logic        q1_valid_b;
  logic        busy_b;

  logic [7:0]  mem_a [128];
  logic [15:0] mem_b [256];
  exp_t        qa [$];
  exp_t        qb [$];
  logic [7:0]  last_a = '0;
  logic [15:0] last_b = '0;
  int          init_cnt = INIT_WORDS;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  unisim_sram_b_param #(
    .ABITS(7), .DBITS(8), .BANK_ABITS(11), .OUT_REG(0), .BYPASS(BYP_A), .INIT_ON_RESET(1)
  ) dut_a (
    .CLK(clk), .RST(rst), .CE0(ce0), .A0(a0[6:0]), .D0(d0[7:0]), .WE0(we0),
    .WEM0(wem0[7:0]), .CE1(ce1), .A1(a1[6:0]), .Q1(q1_a), .Q1_VALID(q1_valid_a),
    .BUSY(busy_a)
  );

  unisim_sram_b_param #(
    .ABITS(8), .DBITS(16), .BANK_ABITS(7), .OUT_REG(1), .BYPASS(BYP_B), .INIT_ON_RESET(1)
  ) dut_b (
    .CLK(clk), .RST(rst), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0),
    .WEM0(wem0), .CE1(ce1), .A1(a1), .Q1(q1_b), .Q1_VALID(q1_valid_b),
    .BUSY(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference init tracker: 128 busy cycles after reset; the array reads as zero afterwards.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt = INIT_WORDS;
      for (int i = 0; i < 128; i++) mem_a[i] = '0;
      for (int i = 0; i < 256; i++) mem_b[i] = '0;
    end else if (init_cnt > 0) begin
      init_cnt--;
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] d,
                                        input logic [15:0] m);
    return (old_w & ~m) | (d & m);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of port activity and predict what the model memory returns.
  task automatic applyStimulus(input logic c0, input logic w0, input logic [7:0] wa,
                               input logic [15:0] wd, input logic [15:0] wm,
                               input logic c1, input logic [7:0] ra);
    int   n;
    logic acc;
    logic wr;
    exp_t e;
    logic [15:0] old_w;
    @(posedge clk);
    #1;
    ce0 = c0; we0 = w0; a0 = wa; d0 = wd; wem0 = wm; ce1 = c1; a1 = ra;
    n   = cyc + 1;
    acc = (init_cnt == 0) && !rst;
    wr  = acc && c0 && w0;
    if (acc && c1) begin
      old_w = {8'h00, mem_a[ra[6:0]]};
      if (BYP_A != 0 && wr && wa[6:0] == ra[6:0]) e.data = merge(old_w, {8'h00, wd[7:0]}, {8'h00, wm[7:0]});
      else e.data = old_w;
      e.due = n + LAT_A - 1;
      qa.push_back(e);
      old_w = mem_b[ra];
      if (BYP_B != 0 && wr && wa == ra) e.data = merge(old_w, wd, wm);
      else e.data = old_w;
      e.due = n + LAT_B - 1;
      qb.push_back(e);
    end
    if (wr) begin
      mem_a[wa[6:0]] = 8'(merge({8'h00, mem_a[wa[6:0]]}, {8'h00, wd[7:0]}, {8'h00, wm[7:0]}));
      mem_b[wa] = merge(mem_b[wa], wd, wm);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic write_word(input logic [7:0] wa, input logic [15:0] wd, input logic [15:0] wm);
    applyStimulus(1'b1, 1'b1, wa, wd, wm, 1'b0, 8'h00);
  endtask

  task automatic read_word(input logic [7:0] ra);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b1, ra);
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #1;
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_until_init(input int target);
    for (int i = 0; i < 400 && init_cnt != target; i++) idle(1);
    checkOutput("init_reach", init_cnt, target);
  endtask

  // Monitor: compares valid, data, hold behaviour and BUSY on every falling edge.
  always @(negedge clk) begin
    logic ev;
    if (rst) begin
      checkOutput("rst_q1_a", q1_a, 0);
      checkOutput("rst_valid_a", q1_valid_a, 0);
      checkOutput("rst_busy_a", busy_a, 1);
      checkOutput("rst_q1_b", q1_b, 0);
      checkOutput("rst_valid_b", q1_valid_b, 0);
      checkOutput("rst_busy_b", busy_b, 1);
      qa.delete();
      qb.delete();
      last_a = '0;
      last_b = '0;
    end else begin
      checkOutput("busy_a", busy_a, init_cnt > 0);
      checkOutput("busy_b", busy_b, init_cnt > 0);
      while (qa.size() > 0 && qa[0].due < cyc) void'(qa.pop_front());
      while (qb.size() > 0 && qb[0].due < cyc) void'(qb.pop_front());
      ev = (qa.size() > 0) && (qa[0].due == cyc);
      checkOutput("valid_a", q1_valid_a, ev);
      if (ev) begin
        last_a = qa[0].data[7:0];
        void'(qa.pop_front());
        checkOutput("data_a", q1_a, last_a);
      end else begin
        checkOutput("hold_a", q1_a, last_a);
      end
      ev = (qb.size() > 0) && (qb[0].due == cyc);
      checkOutput("valid_b", q1_valid_b, ev);
      if (ev) begin
        last_b = qb[0].data;
        void'(qb.pop_front());
        checkOutput("data_b", q1_b, last_b);
      end else begin
        checkOutput("hold_b", q1_b, last_b);
      end
    end
  end

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset in mid-init, then a write (and a read) while still busy that must be dropped.
    idle_until_init(INIT_WORDS - 40);
    pulse_reset(1);
    idle_until_init(30);
    applyStimulus(1'b1, 1'b1, 8'h09, 16'h0077, 16'hFFFF, 1'b1, 8'h09);
    idle_until_init(0);
    read_word(8'h09);
    read_word(8'h00);
    read_word(8'h7F);
    read_word(8'hFF);
    idle(2);

    // Masked write: 0xF0 on the narrow instance, 0x00F0 on the wide one.
    write_word(8'h05, 16'h00FF, 16'hFFFF);
    write_word(8'h05, 16'h0000, 16'h0F0F);
    read_word(8'h05);
    idle(2);

    // Collision: write-first on dut_a, read-first on dut_b; a follow-up read sees new data.
    write_word(8'h03, 16'h0011, 16'hFFFF);
    applyStimulus(1'b1, 1'b1, 8'h03, 16'h00AA, 16'hFFFF, 1'b1, 8'h03);
    read_word(8'h03);
    idle(2);

    // Bank switch between back-to-back reads on the two-bank instance.
    write_word(8'h05, 16'hBEEF, 16'hFFFF);
    write_word(8'h85, 16'h5678, 16'hFFFF);
    read_word(8'h05);
    read_word(8'h85);
    read_word(8'h05);
    idle(2);

    // Idle hold after a read.
    write_word(8'h20, 16'h005A, 16'hFFFF);
    read_word(8'h20);
    idle(10);

    // Randomised traffic over a small address window so collisions happen often.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] wa, ra;
      wa = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00);
      ra = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00);
      if ($urandom_range(0, 3) == 0) ra = wa;
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa,
                    16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    idle(5);

    checkOutput("drain_a", qa.size(), 0);
    checkOutput("drain_b", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
